// File: rtl/rename_alias_table_if.sv
// -----------------------------------------------------------------------------
// rename_alias_table_if
//   Bundle of all non-clock signals of the rename/alias-table block.
//
//   Decode group (master -> slave):
//      in_valid, slot_valid[4], rd/rj/rk_idx[4][5], rd/rj/rk_exist[4],
//      rj_raw_pos/rk_raw_pos/rd_waw_pos[4][2] (intra-group checker positions)
//      in_ready (slave -> master)
//   Renamed group (slave -> master):
//      out_valid, out_slot_valid[4], prd/prj/prk/old_prd[4][6], prd_alloc[4]
//      out_ready (master -> slave)
//   Commit / control (master -> slave):
//      cmt_valid[4], cmt_areg[4][5], cmt_preg[4][6], cmt_old_preg[4][6], flush
//   Status (slave -> master):
//      fl_count[6]  free-list occupancy
//
//   modport slave  : the rename table
//   modport master : decode / commit environment
// -----------------------------------------------------------------------------
interface rename_alias_table_if;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       slot_valid;
   logic [3:0][4:0]  rd_idx;
   logic [3:0][4:0]  rj_idx;
   logic [3:0][4:0]  rk_idx;
   logic [3:0]       rd_exist;
   logic [3:0]       rj_exist;
   logic [3:0]       rk_exist;
   logic [3:0][1:0]  rj_raw_pos;
   logic [3:0][1:0]  rk_raw_pos;
   logic [3:0][1:0]  rd_waw_pos;

   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_slot_valid;
   logic [3:0][5:0]  prd;
   logic [3:0][5:0]  prj;
   logic [3:0][5:0]  prk;
   logic [3:0][5:0]  old_prd;
   logic [3:0]       prd_alloc;

   logic [3:0]       cmt_valid;
   logic [3:0][4:0]  cmt_areg;
   logic [3:0][5:0]  cmt_preg;
   logic [3:0][5:0]  cmt_old_preg;
   logic             flush;
   logic [5:0]       fl_count;

   modport master (
      output in_valid, slot_valid, rd_idx, rj_idx, rk_idx,
             rd_exist, rj_exist, rk_exist, rj_raw_pos, rk_raw_pos, rd_waw_pos,
             out_ready, cmt_valid, cmt_areg, cmt_preg, cmt_old_preg, flush,
      input  in_ready, out_valid, out_slot_valid, prd, prj, prk, old_prd,
             prd_alloc, fl_count
   );

   modport slave (
      input  in_valid, slot_valid, rd_idx, rj_idx, rk_idx,
             rd_exist, rj_exist, rk_exist, rj_raw_pos, rk_raw_pos, rd_waw_pos,
             out_ready, cmt_valid, cmt_areg, cmt_preg, cmt_old_preg, flush,
      output in_ready, out_valid, out_slot_valid, prd, prj, prk, old_prd,
             prd_alloc, fl_count
   );
endinterface

// File: rtl/rename_alias_table.sv
// -----------------------------------------------------------------------------
// rename_alias_table
//   Register-rename stage for a 4-wide decode group. Allocates physical
//   destinations from a circular free list, keeps a speculative alias table
//   (rat) and a committed one (crat), returns freed tags on commit and
//   restores the committed view on flush. Result is one registered stage
//   with valid/ready handshake.
//
//   Ports:
//      clk        clock
//      rst        asynchronous active-high reset
//      bus        rename_alias_table_if.slave (decode group, renamed group,
//                 commit, flush, fl_count)
//      stall_cnt  (only with RENAME_STALL_CNT_EN) saturating count of cycles
//                 where a valid group was refused for reasons other than flush
//
//   Optional feature macro: RENAME_STALL_CNT_EN
// -----------------------------------------------------------------------------
module rename_alias_table #(
   parameter int PREG_NUM = 64,
   parameter int AREG_NUM = 32,
   parameter int FL_DEPTH = PREG_NUM - AREG_NUM
) (
   input  logic                 clk,
   input  logic                 rst,
   rename_alias_table_if.slave  bus
`ifdef RENAME_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);
   localparam int TW = $clog2(PREG_NUM);   // physical tag width
   localparam int IW = $clog2(FL_DEPTH);   // free-list index width
   localparam int PW = IW + 1;             // pointer width incl. wrap bit

   logic [TW-1:0] rat       [AREG_NUM];
   logic [TW-1:0] crat      [AREG_NUM];
   logic [TW-1:0] free_list [FL_DEPTH];
   logic [PW-1:0] head_reg, cmt_head_reg, tail_reg;

   logic [3:0]    need;
   logic [2:0]    alloc_off [4];
   logic [2:0]    cmt_off   [4];
   logic [2:0]    n_alloc, n_cmt;
   logic [PW-1:0] fl_count;
   logic          accept;

   logic [PW-1:0] fl_rd_ptr [4];
   logic [PW-1:0] fl_wr_ptr [4];
   logic [TW-1:0] new_tag   [4];
   logic [TW-1:0] prd_c     [4];
   logic [TW-1:0] prj_c     [4];
   logic [TW-1:0] prk_c     [4];
   logic [TW-1:0] old_c     [4];

   logic             out_valid_reg;
   logic [3:0]       out_slot_valid_reg;
   logic [3:0]       prd_alloc_reg;
   logic [3:0][TW-1:0] prd_reg, prj_reg, prk_reg, old_reg;

   // Prefix counts: each allocating slot reads the free list at head plus the
   // number of allocating slots before it; commits push at tail likewise.
   always_comb begin
      n_alloc = '0;
      n_cmt   = '0;
      need    = '0;
      for (int i = 0; i < 4; i++) begin
         need[i]      = bus.slot_valid[i] & bus.rd_exist[i] & (bus.rd_idx[i] != '0);
         alloc_off[i] = n_alloc;
         cmt_off[i]   = n_cmt;
         n_alloc      = n_alloc + {2'b00, need[i]};
         n_cmt        = n_cmt + {2'b00, bus.cmt_valid[i]};
      end
   end

   assign fl_count     = tail_reg - head_reg;
   assign bus.fl_count = fl_count;
   assign bus.in_ready = (!out_valid_reg | bus.out_ready) & (fl_count >= PW'(n_alloc)) & !bus.flush;
   assign accept       = bus.in_valid & bus.in_ready;

   // A checker position below the own slot forwards that slot's new tag;
   // anything else (own slot, or a malformed later slot) reads the table.
   function automatic logic [TW-1:0] src_sel(input logic          present,
                                             input logic [1:0]    pos,
                                             input logic [1:0]    self,
                                             input logic [TW-1:0] table_tag,
                                             input logic [TW-1:0] fwd_tag);
      if (!present)
         return '0;
      return (pos < self) ? fwd_tag : table_tag;
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign fl_rd_ptr[gi] = head_reg + PW'(alloc_off[gi]);
      assign fl_wr_ptr[gi] = tail_reg + PW'(cmt_off[gi]);
      assign new_tag[gi]   = free_list[fl_rd_ptr[gi][IW-1:0]];
      assign prd_c[gi]     = need[gi] ? new_tag[gi] : '0;
      assign prj_c[gi]     = src_sel(bus.slot_valid[gi] & bus.rj_exist[gi] & (bus.rj_idx[gi] != '0),
                                     bus.rj_raw_pos[gi], 2'(gi),
                                     rat[bus.rj_idx[gi]], new_tag[bus.rj_raw_pos[gi]]);
      assign prk_c[gi]     = src_sel(bus.slot_valid[gi] & bus.rk_exist[gi] & (bus.rk_idx[gi] != '0),
                                     bus.rk_raw_pos[gi], 2'(gi),
                                     rat[bus.rk_idx[gi]], new_tag[bus.rk_raw_pos[gi]]);
      assign old_c[gi]     = src_sel(need[gi],
                                     bus.rd_waw_pos[gi], 2'(gi),
                                     rat[bus.rd_idx[gi]], new_tag[bus.rd_waw_pos[gi]]);
   end

   // Alias tables, free list and pointers. Writes inside the slot loops are
   // in ascending slot order, so the highest slot wins on an areg conflict.
   always_ff @(posedge clk or posedge rst) begin : p_tables
      if (rst) begin
         for (int a = 0; a < AREG_NUM; a++) begin
            rat[a]  <= TW'(a);
            crat[a] <= TW'(a);
         end
         for (int k = 0; k < FL_DEPTH; k++)
            free_list[k] <= TW'(AREG_NUM + k);
         head_reg     <= '0;
         cmt_head_reg <= '0;
         tail_reg     <= PW'(FL_DEPTH);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (bus.cmt_valid[i]) begin
               crat[bus.cmt_areg[i]]               <= bus.cmt_preg[i];
               free_list[fl_wr_ptr[i][IW-1:0]]     <= bus.cmt_old_preg[i];
            end
         end
         tail_reg     <= tail_reg + PW'(n_cmt);
         cmt_head_reg <= cmt_head_reg + PW'(n_cmt);
         if (bus.flush) begin
            // Restore the committed view including this cycle's commits.
            for (int a = 0; a < AREG_NUM; a++)
               rat[a] <= crat[a];
            for (int i = 0; i < 4; i++)
               if (bus.cmt_valid[i])
                  rat[bus.cmt_areg[i]] <= bus.cmt_preg[i];
            head_reg <= cmt_head_reg + PW'(n_cmt);
         end else if (accept) begin
            for (int i = 0; i < 4; i++)
               if (need[i])
                  rat[bus.rd_idx[i]] <= new_tag[i];
            head_reg <= head_reg + PW'(n_alloc);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin : p_out
      if (rst) begin
         out_valid_reg      <= 1'b0;
         out_slot_valid_reg <= '0;
         prd_alloc_reg      <= '0;
         prd_reg            <= '0;
         prj_reg            <= '0;
         prk_reg            <= '0;
         old_reg            <= '0;
      end else if (bus.flush) begin
         out_valid_reg <= 1'b0;
      end else if (accept) begin
         out_valid_reg      <= 1'b1;
         out_slot_valid_reg <= bus.slot_valid;
         prd_alloc_reg      <= need;
         for (int i = 0; i < 4; i++) begin
            prd_reg[i] <= prd_c[i];
            prj_reg[i] <= prj_c[i];
            prk_reg[i] <= prk_c[i];
            old_reg[i] <= old_c[i];
         end
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.out_valid      = out_valid_reg;
   assign bus.out_slot_valid = out_slot_valid_reg;
   assign bus.prd_alloc      = prd_alloc_reg;
   assign bus.prd            = prd_reg;
   assign bus.prj            = prj_reg;
   assign bus.prk            = prk_reg;
   assign bus.old_prd        = old_reg;

`ifdef RENAME_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin : p_stall
      if (rst)
         stall_cnt <= '0;
      else if (bus.in_valid & !bus.in_ready & !bus.flush & (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

   // Returning more tags than were ever taken would overflow the free list.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (({1'b0, fl_count} + (PW+1)'(n_cmt) - (accept ? (PW+1)'(n_alloc) : (PW+1)'(0)))
       <= (PW+1)'(FL_DEPTH)));

endmodule

// File: tb/tb_rename_alias_table.sv
module tb_rename_alias_table;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rename_alias_table_if bus ();
`ifdef RENAME_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   rename_alias_table dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef RENAME_STALL_CNT_EN
      , .stall_cnt (stall_cnt)
`endif
   );

   // Reference model: alias tables as int arrays, the free list as a queue
   // starting at the committed head, plus an in-order list of renamed writers.
   typedef struct { int areg; int preg; int old; } rob_t;
   int   rat_m [32];
   int   crat_m[32];
   int   cq[$];
   int   spec;          // tags taken speculatively from the front of cq
   bit   ov_m;
   rob_t rob[$];
   logic [3:0][5:0] prd_e, prj_e, prk_e, old_e;
   logic [3:0]      alloc_e, sv_e;
   int   stall_m;
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit need_of(int i);
      return bus.slot_valid[i] && bus.rd_exist[i] && (bus.rd_idx[i] != 5'd0);
   endfunction

   // Tag of a source: nearest earlier allocating writer in the group, else table.
   function automatic int src_m(int i, logic ex, logic [4:0] idx, int nt[4]);
      int t;
      if (!bus.slot_valid[i] || !ex || idx == 5'd0) return 0;
      t = rat_m[idx];
      for (int j = 0; j < i; j++)
         if (need_of(j) && bus.rd_idx[j] == idx) t = nt[j];
      return t;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 32; a++) begin
         rat_m[a]  = a;
         crat_m[a] = a;
      end
      cq.delete();
      for (int k = 0; k < 32; k++) cq.push_back(32 + k);
      spec = 0; ov_m = 0; rob.delete(); stall_m = 0;
      prd_e = '0; prj_e = '0; prk_e = '0; old_e = '0; alloc_e = '0; sv_e = '0;
   endtask

   task automatic clear_inputs();
      bus.in_valid = 0; bus.slot_valid = '0;
      bus.rd_idx = '0; bus.rj_idx = '0; bus.rk_idx = '0;
      bus.rd_exist = '0; bus.rj_exist = '0; bus.rk_exist = '0;
      bus.rj_raw_pos = '0; bus.rk_raw_pos = '0; bus.rd_waw_pos = '0;
      bus.cmt_valid = '0; bus.cmt_areg = '0; bus.cmt_preg = '0; bus.cmt_old_preg = '0;
      bus.flush = 0; bus.out_ready = 1;
   endtask

   task automatic set_slot(int i, int rd, bit rde, int rj, bit rje, int rk, bit rke);
      bus.slot_valid[i] = 1'b1;
      bus.rd_idx[i] = 5'(rd); bus.rd_exist[i] = rde;
      bus.rj_idx[i] = 5'(rj); bus.rj_exist[i] = rje;
      bus.rk_idx[i] = 5'(rk); bus.rk_exist[i] = rke;
   endtask

   // Behave like the upstream dependency checker.
   task automatic fix_pos();
      for (int i = 0; i < 4; i++) begin
         int pj, pk, pd;
         pj = i; pk = i; pd = i;
         for (int j = 0; j < i; j++) begin
            if (need_of(j)) begin
               if (bus.rd_idx[j] == bus.rj_idx[i]) pj = j;
               if (bus.rd_idx[j] == bus.rk_idx[i]) pk = j;
               if (bus.rd_idx[j] == bus.rd_idx[i]) pd = j;
            end
         end
         bus.rj_raw_pos[i] = 2'(pj);
         bus.rk_raw_pos[i] = 2'(pk);
         bus.rd_waw_pos[i] = 2'(pd);
      end
   endtask

   task automatic add_commits(int k, bit rnd);
      for (int i = 0; i < 4; i++) begin
         if (k > 0 && rob.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            rob_t e;
            e = rob.pop_front();
            bus.cmt_valid[i]    = 1'b1;
            bus.cmt_areg[i]     = 5'(e.areg);
            bus.cmt_preg[i]     = 6'(e.preg);
            bus.cmt_old_preg[i] = 6'(e.old);
            k--;
         end
      end
   endtask

   // One clock cycle: check in_ready, advance the model, check registered outputs.
   task automatic step();
      int n, c, avail;
      int nt[4];
      bit exp_rdy, acc;
      #1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         nt[i] = 0;
         if (need_of(i)) begin
            if (spec + n < cq.size()) nt[i] = cq[spec + n];
            n++;
         end
      end
      avail   = cq.size() - spec;
      exp_rdy = (!ov_m || bus.out_ready) && (avail >= n) && !bus.flush;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      acc = bus.in_valid && exp_rdy;
      if (bus.in_valid && !exp_rdy && !bus.flush) stall_m++;
      if (acc) begin
         for (int i = 0; i < 4; i++) begin
            prd_e[i]   = need_of(i) ? 6'(nt[i]) : 6'd0;
            prj_e[i]   = 6'(src_m(i, bus.rj_exist[i], bus.rj_idx[i], nt));
            prk_e[i]   = 6'(src_m(i, bus.rk_exist[i], bus.rk_idx[i], nt));
            old_e[i]   = 6'(src_m(i, bus.rd_exist[i], bus.rd_idx[i], nt));
            alloc_e[i] = need_of(i);
         end
         sv_e = bus.slot_valid;
         for (int i = 0; i < 4; i++) begin
            if (need_of(i)) begin
               rob.push_back('{areg: int'(bus.rd_idx[i]), preg: nt[i], old: int'(old_e[i])});
               rat_m[bus.rd_idx[i]] = nt[i];
            end
         end
         spec += n;
         ov_m = 1;
      end else if (bus.out_ready) begin
         ov_m = 0;
      end
      c = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.cmt_valid[i]) begin
            crat_m[bus.cmt_areg[i]] = int'(bus.cmt_preg[i]);
            void'(cq.pop_front());
            cq.push_back(int'(bus.cmt_old_preg[i]));
            c++;
         end
      end
      spec -= c;
      if (bus.flush) begin
         rat_m = crat_m;
         spec = 0;
         rob.delete();
         ov_m = 0;
      end
      @(posedge clk);
      #1;
      step_no++;
      chk("out_valid", 32'(bus.out_valid), 32'(ov_m));
      chk("fl_count", 32'(bus.fl_count), 32'(cq.size() - spec));
      if (ov_m) begin
         chk("out_slot_valid", 32'(bus.out_slot_valid), 32'(sv_e));
         chk("prd", 32'(bus.prd), 32'(prd_e));
         chk("prj", 32'(bus.prj), 32'(prj_e));
         chk("prk", 32'(bus.prk), 32'(prk_e));
         chk("old_prd", 32'(bus.old_prd), 32'(old_e));
         chk("prd_alloc", 32'(bus.prd_alloc), 32'(alloc_e));
      end
`ifdef RENAME_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(stall_m));
`endif
      $display("step %0d acc=%0b n=%0d cmt=%0d flush=%0b fl=%0d out_valid=%0b",
               step_no, acc, n, c, bus.flush, bus.fl_count, bus.out_valid);
   endtask

   // Asynchronous reset taken between clock edges; outputs must clear at once.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_fl_count", 32'(bus.fl_count), 32'd32);
      chk("rst_prd", 32'(bus.prd), 32'd0);
      chk("rst_prd_alloc", 32'(bus.prd_alloc), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1;
   endtask

   function automatic int ridx();
      return ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
   endfunction

   task automatic rand_group();
      clear_inputs();
      for (int i = 0; i < 4; i++)
         if ($urandom_range(0, 3) != 0)
            set_slot(i, ridx(), $urandom_range(0, 3) != 0, ridx(), $urandom_range(0, 1) == 1,
                     ridx(), $urandom_range(0, 1) == 1);
      bus.in_valid  = ($urandom_range(0, 4) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      add_commits(4, 1'b1);
      fix_pos();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_fl_count", 32'(bus.fl_count), 32'd32);
      chk("reset_tags", 32'(bus.prd | bus.prj | bus.prk | bus.old_prd), 32'd0);
      chk("reset_flags", 32'({bus.prd_alloc, bus.out_slot_valid}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single rename from reset.
      clear_inputs();
      set_slot(0, 5, 1, 5, 1, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      chk("t1_prd0", 32'(bus.prd[0]), 32'd32);
      chk("t1_prj0", 32'(bus.prj[0]), 32'd5);
      chk("t1_old0", 32'(bus.old_prd[0]), 32'd5);
      chk("t1_fl", 32'(bus.fl_count), 32'd31);
      clear_inputs();
      step();

      // In-group RAW/WAW.
      do_reset();
      set_slot(0, 3, 1, 0, 0, 0, 0);
      set_slot(1, 3, 1, 3, 1, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      chk("t2_prd0", 32'(bus.prd[0]), 32'd32);
      chk("t2_prj1", 32'(bus.prj[1]), 32'd32);
      chk("t2_prd1", 32'(bus.prd[1]), 32'd33);
      chk("t2_old1", 32'(bus.old_prd[1]), 32'd32);
      clear_inputs();
      set_slot(0, 0, 0, 3, 1, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      chk("t2_rat3", 32'(bus.prj[0]), 32'd33);

      // r0 handling.
      clear_inputs();
      for (int i = 0; i < 4; i++) set_slot(i, 0, 1, 0, 1, 0, 1);
      bus.in_valid = 1;
      fix_pos();
      step();
      chk("t3_alloc", 32'(bus.prd_alloc), 32'd0);
      chk("t3_tags", 32'(bus.prd | bus.prj | bus.old_prd), 32'd0);
      chk("t3_fl", 32'(bus.fl_count), 32'd30);

      // Exhaustion and exact-fit boundary.
      do_reset();
      for (int g = 0; g < 7; g++) begin
         clear_inputs();
         for (int i = 0; i < 4; i++) set_slot(i, 1 + ((g * 4 + i) % 31), 1, 0, 0, 0, 0);
         bus.in_valid = 1;
         fix_pos();
         step();
      end
      clear_inputs();
      set_slot(0, 9, 1, 0, 0, 0, 0);
      set_slot(1, 10, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      chk("t4_fl30", 32'(bus.fl_count), 32'd2);
      clear_inputs();
      for (int i = 0; i < 4; i++) set_slot(i, 11 + i, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      #1;
      chk("t4_blocked", 32'(bus.in_ready), 32'd0);
      step();
      add_commits(2, 1'b0);
      #1;
      chk("t4_blocked_cmt", 32'(bus.in_ready), 32'd0);
      step();
      bus.cmt_valid = '0;
      #1;
      chk("t4_exact_fit", 32'(bus.in_ready), 32'd1);
      step();
      chk("t4_fl0", 32'(bus.fl_count), 32'd0);
      clear_inputs();
      set_slot(0, 7, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      #1;
      chk("t4_empty_blocked", 32'(bus.in_ready), 32'd0);
      step();

      // Flush with same-cycle commit.
      do_reset();
      set_slot(0, 3, 1, 0, 0, 0, 0); set_slot(1, 1, 1, 0, 0, 0, 0);
      set_slot(2, 2, 1, 0, 0, 0, 0); set_slot(3, 4, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      clear_inputs();
      for (int i = 0; i < 4; i++) set_slot(i, 5 + i, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      clear_inputs();
      for (int i = 0; i < 4; i++) set_slot(i, 12 + i, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      bus.flush = 1;
      fix_pos();
      add_commits(1, 1'b0);
      step();
      chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_fl", 32'(bus.fl_count), 32'd32);
      clear_inputs();
      set_slot(0, 0, 0, 3, 1, 0, 0); set_slot(1, 0, 0, 1, 1, 0, 0);
      set_slot(2, 0, 0, 5, 1, 0, 0); set_slot(3, 0, 0, 8, 1, 0, 0);
      bus.in_valid = 1;
      fix_pos();
      step();
      chk("t5_rat3", 32'(bus.prj[0]), 32'd32);
      chk("t5_rat1", 32'(bus.prj[1]), 32'd1);
      chk("t5_rat5", 32'(bus.prj[2]), 32'd5);
      chk("t5_rat8", 32'(bus.prj[3]), 32'd8);

      // Backpressure.
      do_reset();
      for (int i = 0; i < 4; i++) set_slot(i, 1 + i, 1, 0, 0, 0, 0);
      bus.in_valid = 1;
      bus.out_ready = 0;
      fix_pos();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_fl", 32'(bus.fl_count), 32'd28);
         for (int i = 0; i < 4; i++) chk("t6_prd", 32'(bus.prd[i]), 32'(32 + i));
      end
      bus.out_ready = 1;
      step();
      chk("t6_release_fl", 32'(bus.fl_count), 32'd24);

      // Randomized traffic, with one reset taken mid-operation.
      do_reset();
      for (int it = 0; it < 400; it++) begin
         rand_group();
         if (it == 200) do_reset();
         else step();
      end
      clear_inputs();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
